redirect_sched: RTL

- Central PC-redirect and pipeline-flush scheduler for the 16-bit 5-stage CPU.
- Takes resolved redirect requests from EXE (taken branch/jal/jr, exec) and load-use hazards from ID.
- Drives the PC mux load, IF/ID and ID/EX flush and stall controls, and an EXE bubble.
- Owns the exec round-trip: jump to the exec target, wait for that one instruction to retire, then return to the saved PC+1.

---
 rtl/redirect_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/redirect_sched.sv
// PC-redirect / pipeline-flush scheduler for the 5-stage CPU.
// All outputs are registered; the exec round-trip lives in FLUSH/EXEC_WAIT.
module redirect_sched #(
  parameter int FLUSH_CYCLES = 3,
  parameter int PC_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_req,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            exec_req,
  input  logic [PC_W-1:0] exec_target,
  input  logic [PC_W-1:0] exec_ret_pc,
  input  logic            slot_retire,
  input  logic            lduse_hazard,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            nop_exe,
  output logic            in_exec,
  output logic            exec_err
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, EXEC_WAIT = 2'd2} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic            ret_flag_reg, ret_flag_next;   // 1: return to EXEC_WAIT
  logic [PC_W-1:0] ret_pc_reg, ret_pc_next;

  logic            pc_load_reg, pc_load_next;
  logic [PC_W-1:0] pc_next_reg, pc_next_next;
  logic            flush_reg, flush_next;
  logic            stall_reg, stall_next;
  logic            nop_exe_reg, nop_exe_next;
  logic            in_exec_reg, in_exec_next;
  logic            exec_err_reg, exec_err_next;

  // Event decode shared by next-state and output logic
  logic            in_run, in_wait;
  logic            take_branch, take_exec, take_return, do_redirect, do_stall;
  logic [PC_W-1:0] redirect_addr;

  always_comb begin
    in_run        = (state_reg == RUN);
    in_wait       = (state_reg == EXEC_WAIT);
    take_branch   = redirect_req & (in_run | (in_wait & slot_retire));
    take_exec     = in_run & exec_req & ~redirect_req;
    take_return   = in_wait & slot_retire & ~redirect_req;
    do_redirect   = take_branch | take_exec | take_return;
    do_stall      = (in_run | in_wait) & lduse_hazard & ~do_redirect;
    redirect_addr = redirect_target;
    if (take_exec) begin
      redirect_addr = exec_target;
    end else if (take_return) begin
      redirect_addr = ret_pc_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      cnt_reg      <= 3'd0;
      ret_flag_reg <= 1'b0;
      ret_pc_reg   <= '0;
      pc_load_reg  <= 1'b0;
      pc_next_reg  <= '0;
      flush_reg    <= 1'b0;
      stall_reg    <= 1'b0;
      nop_exe_reg  <= 1'b0;
      in_exec_reg  <= 1'b0;
      exec_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ret_flag_reg <= ret_flag_next;
      ret_pc_reg   <= ret_pc_next;
      pc_load_reg  <= pc_load_next;
      pc_next_reg  <= pc_next_next;
      flush_reg    <= flush_next;
      stall_reg    <= stall_next;
      nop_exe_reg  <= nop_exe_next;
      in_exec_reg  <= in_exec_next;
      exec_err_reg <= exec_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ret_flag_next = ret_flag_reg;
    ret_pc_next   = ret_pc_reg;
    case (state_reg)
      RUN, EXEC_WAIT: begin
        if (do_redirect) begin
          state_next    = FLUSH;
          cnt_next      = CNT_INIT;
          ret_flag_next = take_exec;
        end
        if (take_exec) begin
          ret_pc_next = exec_ret_pc;
        end
      end
      FLUSH: begin
        // Wrong-path requests are ignored for the whole flush window
        if (cnt_reg == 3'd0) begin
          state_next = ret_flag_reg ? EXEC_WAIT : RUN;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_comb begin
    pc_load_next  = do_redirect;
    pc_next_next  = do_redirect ? redirect_addr : pc_next_reg;
    flush_next    = do_redirect | ((state_reg == FLUSH) & (cnt_reg != 3'd0));
    stall_next    = do_stall;
    nop_exe_next  = flush_next | do_stall;
    exec_err_next = in_wait & exec_req;
    in_exec_next  = in_exec_reg;
    if (take_exec) begin
      in_exec_next = 1'b1;
    end else if (in_wait & slot_retire) begin
      in_exec_next = 1'b0;
    end
  end

  assign pc_load    = pc_load_reg;
  assign pc_next    = pc_next_reg;
  assign flush_ifid = flush_reg;
  assign flush_idex = flush_reg;
  assign stall_pc   = stall_reg;
  assign stall_ifid = stall_reg;
  assign nop_exe    = nop_exe_reg;
  assign in_exec    = in_exec_reg;
  assign exec_err   = exec_err_reg;

endmodule
